// File: rtl/bcd_seg7_driver.sv
// Converts a CPU-written 32-bit unsigned value to decimal with a sequential
// double-dabble engine and drives eight active-low seven-segment displays.
module bcd_seg7_driver #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_we,
  input  logic [31:0] io_data,
  output logic        busy,
  output logic        ovf,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;

  state_t      state, state_nxt;
  logic        pending;
  logic [31:0] pend_val;
  logic [31:0] bin_sr;
  logic [39:0] bcd;
  logic [39:0] bcd_adj;
  logic [4:0]  cnt;
  logic [6:0]  hex_r [8];
  logic [6:0]  hex_nxt [8];
  logic        ovf_nxt;

  function automatic logic [39:0] dabble_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign bcd_adj = dabble_adjust(bcd);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == 5'd31) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Segment images from the finished BCD word; leading zeros blank only in range
  always_comb begin
    logic seen;
    seen    = 1'b0;
    ovf_nxt = (bcd[39:32] != 8'd0);
    for (int i = 7; i >= 0; i--) begin
      seen       = seen | (bcd[4*i +: 4] != 4'd0) | (i == 0);
      hex_nxt[i] = (BLANK_LZ && !ovf_nxt && !seen) ? 7'h7F : seg7(bcd[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      ovf     <= 1'b0;
      for (int i = 0; i < 8; i++) hex_r[i] <= 7'h7F;
    end else begin
      state <= state_nxt;
      if (io_we)                          pending <= 1'b1;
      else if (state == IDLE && pending)  pending <= 1'b0;
      if (state == UPDATE) begin
        ovf <= ovf_nxt;
        for (int i = 0; i < 8; i++) hex_r[i] <= hex_nxt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (io_we) pend_val <= io_data;
    case (state)
      LOAD: begin
        bin_sr <= pend_val;
        bcd    <= 40'd0;
        cnt    <= 5'd0;
      end
      SHIFT: begin
        bcd    <= {bcd_adj[38:0], bin_sr[31]};
        bin_sr <= {bin_sr[30:0], 1'b0};
        cnt    <= cnt + 5'd1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE) | pending;
  assign HEX0 = hex_r[0];
  assign HEX1 = hex_r[1];
  assign HEX2 = hex_r[2];
  assign HEX3 = hex_r[3];
  assign HEX4 = hex_r[4];
  assign HEX5 = hex_r[5];
  assign HEX6 = hex_r[6];
  assign HEX7 = hex_r[7];

endmodule

// File: tb/tb_bcd_seg7_driver.sv
// Directed bench for bcd_seg7_driver: one blanking instance and one
// all-digits instance share the same stimulus.
module tb_bcd_seg7_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        io_we = 1'b0;
  logic [31:0] io_data = 32'd0;
  logic        busy, ovf, busy_nb, ovf_nb;
  logic [6:0]  h0, h1, h2, h3, h4, h5, h6, h7;
  logic [6:0]  n0, n1, n2, n3, n4, n5, n6, n7;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  bcd_seg7_driver #(.BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .io_we(io_we), .io_data(io_data), .busy(busy), .ovf(ovf),
    .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5), .HEX6(h6), .HEX7(h7)
  );

  bcd_seg7_driver #(.BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .io_we(io_we), .io_data(io_data), .busy(busy_nb), .ovf(ovf_nb),
    .HEX0(n0), .HEX1(n1), .HEX2(n2), .HEX3(n3), .HEX4(n4), .HEX5(n5), .HEX6(n6), .HEX7(n7)
  );

  wire [55:0] hex    = {h7, h6, h5, h4, h3, h2, h1, h0};
  wire [55:0] hex_nb = {n7, n6, n5, n4, n3, n2, n1, n0};

  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};
  localparam logic [55:0] ALL_ZERO  = {8{7'h40}};
  localparam logic [55:0] ALL_NINE  = {8{7'h10}};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The edge consumed here is E0 of the write
  task automatic write(input logic [31:0] v);
    io_data = v;
    io_we   = 1'b1;
    step(1);
    io_we   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // T1: reset state, then 12345
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_hex", hex, ALL_BLANK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    write(32'd12345);
    chk("t1_busy_after_we", busy, 1'b1);
    step(34);
    chk("t1_hex_e34_unchanged", hex, ALL_BLANK);
    chk("t1_busy_e34", busy, 1'b1);
    step(1);
    chk("t1_hex_e35", hex, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
    chk("t1_hex_nb", hex_nb, {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
    chk("t1_ovf", ovf, 1'b0);
    step(1);
    chk("t1_busy_e36", busy, 1'b0);

    // T2: zero
    write(32'd0);
    step(35);
    chk("t2_hex", hex, {{7{7'h7F}}, 7'h40});
    chk("t2_hex_nb", hex_nb, ALL_ZERO);
    chk("t2_ovf", ovf, 1'b0);

    // T3: maximum value overflows the eight displays
    write(32'hFFFF_FFFF);
    step(35);
    chk("t3_hex", hex, {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12});
    chk("t3_ovf", ovf, 1'b1);
    chk("t3_ovf_nb", ovf_nb, 1'b1);

    // T4: overflow boundary
    write(32'd100000000);
    step(35);
    chk("t4a_hex", hex, ALL_ZERO);
    chk("t4a_ovf", ovf, 1'b1);
    write(32'd99999999);
    step(35);
    chk("t4b_hex", hex, ALL_NINE);
    chk("t4b_ovf", ovf, 1'b0);

    // T5: writes during a conversion, last one wins
    write(32'd100);
    step(9);
    write(32'd7);
    step(1);
    write(32'd99999999);
    step(22);
    chk("t5_hex_e34_old", hex, ALL_NINE);
    chk("t5_busy_e34", busy, 1'b1);
    step(1);
    chk("t5_hex_e35", hex, {{5{7'h7F}}, 7'h79, 7'h40, 7'h40});
    chk("t5_busy_e35", busy, 1'b1);
    step(1);
    chk("t5_busy_e36", busy, 1'b1);
    step(33);
    chk("t5_hex_e69_hold", hex, {{5{7'h7F}}, 7'h79, 7'h40, 7'h40});
    chk("t5_busy_e69", busy, 1'b1);
    step(2);
    chk("t5_hex_e71", hex, ALL_NINE);
    chk("t5_ovf_e71", ovf, 1'b0);
    step(1);
    chk("t5_busy_e72", busy, 1'b0);

    // T6: reset mid-conversion aborts, then a fresh write
    write(32'd555);
    step(19);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_rst_hex", hex, ALL_BLANK);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_ovf", ovf, 1'b0);
    step(40);
    chk("t6_no_update", hex, ALL_BLANK);
    chk("t6_idle_busy", busy, 1'b0);
    write(32'd4096);
    step(34);
    chk("t6_hex_e34", hex, ALL_BLANK);
    step(1);
    chk("t6_hex_e35", hex, {{4{7'h7F}}, 7'h19, 7'h40, 7'h10, 7'h02});
    chk("t6_hex_nb", hex_nb, {{4{7'h40}}, 7'h19, 7'h40, 7'h10, 7'h02});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
